dcm_phase_shift_ctrl: RTL and testbench

//  Sequences variable phase shift of a DCM_SP in the clock/reset generator; drives PSEN/PSINCDEC on the DCM PSCLK domain (= clk).

---
 rtl/dcm_phase_shift_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dcm_phase_shift_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_phase_shift_ctrl.sv
// ---------------------------------------------------------------------------
// dcm_phase_shift_ctrl
//   Sequences variable phase shift of a DCM_SP. Runs on the DCM PSCLK (clk).
//   A signed step request is range-checked against the tracked absolute phase
//   offset, then issued as one PSEN pulse per step, waiting for PSDONE before
//   the next pulse. Aborts on a missing PSDONE (timeout) or on DCM lock loss.
//
// Ports
//   clk          in   DCM PSCLK, all logic on posedge
//   reset_n      in   asynchronous active-low reset
//   dcm_locked   in   DCM LOCKED (async), 2-flop synchronized to locked_s
//   req_valid    in   shift request valid
//   req_steps    in   signed step count, + = increment
//   req_ready    out  request accepted this cycle when req_valid is high
//   ps_en        out  DCM PSEN, single-cycle pulses
//   ps_incdec    out  DCM PSINCDEC, 1 = increment
//   ps_done      in   DCM PSDONE
//   busy         out  shift operation in progress
//   phase        out  current signed (two's complement) phase offset in steps
//   done         out  1-cycle pulse: request completed
//   err_range    out  1-cycle pulse: request rejected, target out of range
//   err_timeout  out  1-cycle pulse: ps_done missing, operation aborted
//   state_dbg    out  current FSM state (WAIT_LOCK=0 IDLE=1 ISSUE=2
//                     WAIT_DONE=3 FINISH=4)
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready does not depend on req_valid. Requests
// offered while req_ready is low are dropped, never queued.
// ---------------------------------------------------------------------------
module dcm_phase_shift_ctrl #(
  parameter int STEP_W    = 8,
  parameter int PHASE_W   = 9,
  parameter int PHASE_MAX = 255,
  parameter int TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dcm_locked,
  input  logic               req_valid,
  input  logic [STEP_W-1:0]  req_steps,
  output logic               req_ready,
  output logic               ps_en,
  output logic               ps_incdec,
  input  logic               ps_done,
  output logic               busy,
  output logic [PHASE_W-1:0] phase,
  output logic               done,
  output logic               err_range,
  output logic               err_timeout,
  output logic [2:0]         state_dbg
);

  // Target is formed one bit wider than phase so phase + step cannot wrap.
  // Requires PHASE_W + 1 > STEP_W.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [PHASE_W:0] LIM_HI    = (PHASE_W + 1)'(PHASE_MAX);
  localparam logic signed [PHASE_W:0] LIM_LO    = -LIM_HI;
  localparam logic [TW-1:0]           TIMER_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0]           ONE_T     = 1;
  localparam logic [STEP_W-1:0]       ONE_S     = 1;
  localparam logic [PHASE_W-1:0]      ONE_P     = 1;

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_IDLE      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  state_t              state;
  logic                locked_meta;
  logic                locked_s;
  logic                ps_en_r;
  logic [STEP_W-1:0]   remaining;
  logic [TW-1:0]       timer;

  logic                req_neg;
  logic [STEP_W-1:0]   req_mag;
  logic signed [PHASE_W:0] target;
  logic                out_of_range;
  logic                accept;

  // Magnitude of the most negative request (e.g. -128) is 2^(STEP_W-1),
  // which still fits as an unsigned STEP_W-bit count.
  assign req_neg      = req_steps[STEP_W-1];
  assign req_mag      = req_neg ? (~req_steps + ONE_S) : req_steps;
  assign target       = $signed({phase[PHASE_W-1], phase})
                      + $signed({{(PHASE_W + 1 - STEP_W){req_neg}}, req_steps});
  assign out_of_range = (target > LIM_HI) || (target < LIM_LO);

  assign req_ready = (state == S_IDLE) && locked_s;
  assign accept    = req_valid && req_ready;
  assign busy      = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_FINISH);
  // Gate PSEN with lock so a pulse never reaches a DCM that just lost lock.
  assign ps_en     = ps_en_r && locked_s;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= dcm_locked;
      locked_s    <= locked_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_WAIT_LOCK;
      phase       <= '0;
      remaining   <= '0;
      timer       <= '0;
      ps_en_r     <= 1'b0;
      ps_incdec   <= 1'b0;
      done        <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      ps_en_r     <= 1'b0;
      if (!locked_s) begin
        // DCM reset on lock loss clears its internal shift, so the offset
        // restarts at zero; the aborted request reports nothing.
        state     <= S_WAIT_LOCK;
        phase     <= '0;
        remaining <= '0;
        timer     <= '0;
        ps_incdec <= 1'b0;
      end else begin
        case (state)
          S_WAIT_LOCK: state <= S_IDLE;
          S_IDLE: begin
            if (accept) begin
              if (out_of_range) begin
                err_range <= 1'b1;
              end else if (req_steps == '0) begin
                done <= 1'b1;
              end else begin
                remaining <= req_mag;
                ps_incdec <= ~req_neg;
                ps_en_r   <= 1'b1;
                state     <= S_ISSUE;
              end
            end
          end
          S_ISSUE: begin
            timer <= '0;
            state <= S_WAIT_DONE;
          end
          S_WAIT_DONE: begin
            if (ps_done) begin
              phase     <= ps_incdec ? (phase + ONE_P) : (phase - ONE_P);
              remaining <= remaining - ONE_S;
              if (remaining == ONE_S) begin
                done  <= 1'b1;
                state <= S_FINISH;
              end else begin
                ps_en_r <= 1'b1;
                state   <= S_ISSUE;
              end
            end else if (timer == TIMER_MAX) begin
              err_timeout <= 1'b1;
              state       <= S_IDLE;
            end else begin
              timer <= timer + ONE_T;
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_WAIT_LOCK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dcm_phase_shift_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcm_phase_shift_ctrl
//   Directed and random shift requests against a simple DCM PSDONE model.
//   Expected phase is tracked as a plain integer: each accepted request moves
//   it by its signed step count unless the result would leave +/-PHASE_MAX.
// ---------------------------------------------------------------------------
module tb_dcm_phase_shift_ctrl;

  localparam int STEP_W    = 8;
  localparam int PHASE_W   = 9;
  localparam int PHASE_MAX = 255;
  localparam int TIMEOUT   = 1023;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic               dcm_locked = 1'b0;
  logic               req_valid = 1'b0;
  logic [STEP_W-1:0]  req_steps = '0;
  logic               req_ready;
  logic               ps_en;
  logic               ps_incdec;
  logic               ps_done;
  logic               busy;
  logic [PHASE_W-1:0] phase;
  logic               done;
  logic               err_range;
  logic               err_timeout;
  logic [2:0]         state_dbg;

  dcm_phase_shift_ctrl #(
    .STEP_W(STEP_W), .PHASE_W(PHASE_W), .PHASE_MAX(PHASE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dcm_locked(dcm_locked),
    .req_valid(req_valid), .req_steps(req_steps), .req_ready(req_ready),
    .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done), .busy(busy),
    .phase(phase), .done(done), .err_range(err_range),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // ---------------- DCM model: PSDONE 2 cycles after PSEN ----------------
  logic p0 = 1'b0, p1 = 1'b0, spur = 1'b0;
  int   model_cnt = 0;
  int   drop_idx  = -1;
  assign ps_done = p1 | spur;
  always @(posedge clk) begin
    p1 <= p0;
    p0 <= 1'b0;
    if (ps_en) begin
      model_cnt = model_cnt + 1;
      if (model_cnt != drop_idx) p0 <= 1'b1;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, en_cnt = 0, done_cnt = 0, rng_cnt = 0, to_cnt = 0;
  int last_en_cyc = 0, to_cyc = 0;
  logic last_incdec = 1'b0;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ps_en) begin
      en_cnt = en_cnt + 1;
      last_en_cyc = cyc;
      last_incdec = ps_incdec;
    end
    if (done) done_cnt = done_cnt + 1;
    if (err_range) rng_cnt = rng_cnt + 1;
    if (err_timeout) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int exp_phase = 0;
  logic [PHASE_W-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int phase_now();
    int v;
    v = $signed(phase);
    return v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_req(input int steps);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 0, 1);
    req_valid = 1'b1;
    req_steps = STEP_W'(steps);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_steps = '0;
  endtask

  task automatic wait_end(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err_range || err_timeout) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) check("end_pulse_wait", 0, 1);
  endtask

  // Issue one request and compare against the integer phase model.
  task automatic run_req(input int steps, input string tag);
    int e0, d0, r0, tgt;
    e0 = en_cnt; d0 = done_cnt; r0 = rng_cnt;
    tgt = exp_phase + steps;
    start_req(steps);
    wait_end(2000);
    if (iabs(tgt) > PHASE_MAX) begin
      check({tag, "_rng"}, rng_cnt - r0, 1);
      check({tag, "_rng_noen"}, en_cnt - e0, 0);
      check({tag, "_rng_nodone"}, done_cnt - d0, 0);
    end else begin
      exp_phase = tgt;
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_en"}, en_cnt - e0, iabs(steps));
      check({tag, "_norng"}, rng_cnt - r0, 0);
      if (steps != 0) check({tag, "_incdec"}, int'(last_incdec), (steps > 0) ? 1 : 0);
    end
    @(negedge clk);
    exp_q.push_back(PHASE_W'(exp_phase));
    check({tag, "_phase"}, phase_now(), $signed(exp_q.pop_front()));
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int e0, d0, t0, n, rs;
    logic [STEP_W-1:0] r;

    // 1: reset state, then lock and sync
    dcm_locked = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_psen", int'(ps_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_phase", phase_now(), 0);
    check("rst_pulses", int'({done, err_range, err_timeout}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("sync_ready_early", int'(req_ready), 0);
    repeat (3) @(negedge clk);
    check("sync_ready", int'(req_ready), 1);
    check("sync_phase", phase_now(), 0);

    // 2: +3
    run_req(3, "inc3");

    // 3: drive to 250, over-range rejected, then -5
    run_req(127, "to130");
    run_req(120, "to250");
    check("at250", phase_now(), 250);
    run_req(10, "over");
    check("over_phase", phase_now(), 250);
    run_req(-5, "dec5");
    check("at245", phase_now(), 245);

    // spurious ps_done while idle is ignored
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_phase", phase_now(), 245);

    // 5: lock loss during WAIT_DONE of +4
    e0 = en_cnt; d0 = done_cnt;
    start_req(4);
    n = 0;
    while (en_cnt - e0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("lock_two_en", en_cnt - e0, 2);
    dcm_locked = 1'b0;
    repeat (8) @(negedge clk);
    exp_phase = 0;
    check("lock_phase", phase_now(), exp_phase);
    check("lock_no_more_en", en_cnt - e0, 2);
    check("lock_no_done", done_cnt - d0, 0);
    check("lock_ready", int'(req_ready), 0);
    check("lock_busy", int'(busy), 0);
    dcm_locked = 1'b1;
    repeat (4) @(negedge clk);
    check("relock_ready", int'(req_ready), 1);

    // 4: +2 with second ps_done dropped -> timeout
    t0 = to_cnt; d0 = done_cnt; e0 = en_cnt;
    drop_idx = model_cnt + 2;
    start_req(2);
    wait_end(3000);
    check("to_pulse", to_cnt - t0, 1);
    check("to_no_done", done_cnt - d0, 0);
    check("to_en", en_cnt - e0, 2);
    check("to_latency_ok",
          int'((to_cyc - last_en_cyc >= TIMEOUT) && (to_cyc - last_en_cyc <= TIMEOUT + 2)), 1);
    exp_phase = 1;
    @(negedge clk);
    check("to_phase", phase_now(), exp_phase);
    check("to_idle_ready", int'(req_ready), 1);
    check("to_idle_busy", int'(busy), 0);
    drop_idx = -1;

    // 6: back to 0, full-scale -128, then a zero request
    run_req(-1, "to0");
    run_req(-128, "m128");
    check("at_m128", phase_now(), -128);
    run_req(0, "zero");

    // random requests over the full step range
    for (int i = 0; i < 30; i++) begin
      r = STEP_W'($urandom_range(0, 255));
      rs = $signed(r);
      run_req(rs, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
